// File: rtl/sequential_sweep_ctrl.sv
// Command-driven sweep sequencer: takes (mode, base, len) from a channel,
// sweeps one memory port, and returns cycle count and read checksum.
module sequential_sweep_ctrl #(
  parameter int SIMD_WIDTH = 1,
  parameter int W_D        = 32,
  parameter int W_A        = 12,
  parameter int W_COMM_D   = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [W_COMM_D-1:0]       comm_q,
  input  logic                      comm_empty,
  output logic                      comm_deq,
  output logic [W_COMM_D-1:0]       comm_d,
  output logic                      comm_enq,
  input  logic                      comm_full,
  output logic [W_A-1:0]            mem_addr,
  output logic [W_D*SIMD_WIDTH-1:0] mem_d,
  output logic                      mem_we,
  input  logic [W_D*SIMD_WIDTH-1:0] mem_q,
  output logic                      busy
);

  localparam int W_M = W_D * SIMD_WIDTH;
  localparam logic [W_COMM_D-1:0] LEN_MAX = W_COMM_D'(1) << W_A;

  localparam logic [3:0] S_ID_REQ   = 4'd0;
  localparam logic [3:0] S_ID_LAT   = 4'd1;
  localparam logic [3:0] S_BASE_REQ = 4'd2;
  localparam logic [3:0] S_BASE_LAT = 4'd3;
  localparam logic [3:0] S_LEN_REQ  = 4'd4;
  localparam logic [3:0] S_LEN_LAT  = 4'd5;
  localparam logic [3:0] S_RUN      = 4'd6;
  localparam logic [3:0] S_DRAIN    = 4'd7;
  localparam logic [3:0] S_TX_CNT   = 4'd8;
  localparam logic [3:0] S_TX_SUM   = 4'd9;

  logic [3:0]          state_q, state_d;
  logic                mode_q, mode_d;
  logic [W_A-1:0]      base_q, base_d;
  logic [W_A:0]        len_q, len_d;
  logic [W_A-1:0]      idx_q, idx_d;
  logic [W_COMM_D-1:0] cnt_q, cnt_d;
  logic [W_COMM_D-1:0] sum_q, sum_d;
  logic [W_A-1:0]      addr_q, addr_d;
  logic [W_M-1:0]      wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                rvld_q, rvld_d;

  logic                deq_c, enq_c;
  logic [W_COMM_D-1:0] cd_c;
  logic [W_COMM_D-1:0] lane_sum;
  logic [W_A:0]        len_in;
  logic                last;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      lane_sum = lane_sum + W_COMM_D'(mem_q[i*W_D +: W_D]);
    end
  end

  // Lengths beyond the address space collapse to one full sweep
  always_comb begin
    len_in = comm_q[W_A:0];
    if (comm_q > LEN_MAX) begin
      len_in = LEN_MAX[W_A:0];
    end
  end

  assign last = ({1'b0, idx_q} == (len_q - 1'b1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    rvld_d  = (state_q == S_RUN) && mode_q;
    deq_c   = 1'b0;
    enq_c   = 1'b0;
    cd_c    = '0;
    if (rvld_q) begin
      sum_d = sum_q + lane_sum;
    end
    unique case (state_q)
      S_ID_REQ: begin
        if (!comm_empty) begin
          deq_c   = 1'b1;
          state_d = S_ID_LAT;
        end
      end
      S_ID_LAT: begin
        mode_d  = comm_q[0];
        state_d = S_BASE_REQ;
      end
      S_BASE_REQ: begin
        if (!comm_empty) begin
          deq_c   = 1'b1;
          state_d = S_BASE_LAT;
        end
      end
      S_BASE_LAT: begin
        base_d  = comm_q[W_A-1:0];
        state_d = S_LEN_REQ;
      end
      S_LEN_REQ: begin
        if (!comm_empty) begin
          deq_c   = 1'b1;
          state_d = S_LEN_LAT;
        end
      end
      S_LEN_LAT: begin
        len_d = len_in;
        cnt_d = '0;
        sum_d = '0;
        idx_d = '0;
        if (len_in == '0) begin
          state_d = S_TX_CNT;
        end else begin
          addr_d  = base_q;
          wdata_d = '0;
          we_d    = !mode_q;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = S_DRAIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          wdata_d = W_M'(idx_d);
          we_d    = !mode_q;
        end
      end
      S_DRAIN: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_TX_CNT;
      end
      S_TX_CNT: begin
        if (!comm_full) begin
          enq_c   = 1'b1;
          cd_c    = cnt_q;
          state_d = S_TX_SUM;
        end
      end
      S_TX_SUM: begin
        if (!comm_full) begin
          enq_c   = 1'b1;
          cd_c    = sum_q;
          state_d = S_ID_REQ;
        end
      end
      default: begin
        state_d = S_ID_REQ;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_ID_REQ;
      mode_q  <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rvld_q  <= rvld_d;
    end
  end

  // Handshake outputs are quiet while reset is held
  assign comm_deq = deq_c & ~RST;
  assign comm_enq = enq_c & ~RST;
  assign comm_d   = RST ? '0 : cd_c;
  assign busy     = (state_q != S_ID_REQ) & ~RST;
  assign mem_addr = addr_q;
  assign mem_d    = wdata_q;
  assign mem_we   = we_q;

endmodule
